// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// counter-width helper.
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bit-count counter width; it only ever has to reach WIDTH-1.
  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, fed one operand bit per clock by serial_adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sout,
  output logic cout
);

  assign sout = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder cell plus a carry flop add two WIDTH-bit
// operands LSB first, presenting the result with a start/done handshake.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int                CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-2:0] s_sh_q, s_sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             fa_sout;
  logic             fa_cout;
  logic [WIDTH-1:0] s_cat;

  full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sout (fa_sout),
    .cout (fa_cout)
  );

  // The newest sum bit enters at the MSB; after WIDTH shifts bit 0 is at the LSB.
  assign s_cat = {fa_sout, s_sh_q};

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_sh_d  = op_a;
          b_sh_d  = op_b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        s_sh_d  = s_cat[WIDTH-1:1];
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = fa_cout;
        if (cnt_q == CNT_LAST) begin
          sum_d   = s_cat;
          cout_d  = fa_cout;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 directed cases and a WIDTH=4 exhaustive
// sweep, both checked every cycle against a cycle-count reference model.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0, cin8 = 1'b0, start4 = 1'b0, cin4 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic [3:0] a4 = '0, b4 = '0, sum4;
  logic       busy8, done8, cout8, busy4, done4, cout4;

  int checks = 0;
  int errors = 0;

  // Model: an accepted op is busy for WIDTH edges, then its value appears.
  int edge_n = 0;
  int acc[2]    = '{0, 0};
  int pend[2]   = '{0, 0};
  int res[2]    = '{0, 0};
  bit m_busy[2] = '{0, 0};
  bit m_done[2] = '{0, 0};

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op_a(a8), .op_b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .op_a(a4), .op_b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k, input int w, input logic st,
                            input logic [7:0] a, input logic [7:0] b, input logic c);
    m_done[k] = 1'b0;
    if (m_busy[k]) begin
      if (edge_n == acc[k] + w) begin
        res[k]    = pend[k];
        m_busy[k] = 1'b0;
        m_done[k] = 1'b1;
      end
    end else if (st) begin
      acc[k]    = edge_n;
      pend[k]   = int'(a) + int'(b) + int'(c);
      m_busy[k] = 1'b1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < 2; k++) begin
          m_busy[k] = 1'b0;
          m_done[k] = 1'b0;
          res[k]    = 0;
        end
      end else begin
        edge_n++;
        model_step(0, 8, start8, a8, b8, cin8);
        model_step(1, 4, start4, {4'b0, a4}, {4'b0, b4}, cin4);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("done8", 32'(done8), 32'(m_done[0]));
        check("busy8", 32'(busy8), 32'(m_busy[0]));
        check("sum8", 32'(sum8), 32'(res[0] & 32'hFF));
        check("cout8", 32'(cout8), 32'((res[0] >> 8) & 1));
        check("excl8", 32'(busy8 & done8), 32'd0);
        check("done4", 32'(done4), 32'(m_done[1]));
        check("busy4", 32'(busy4), 32'(m_busy[1]));
        check("sum4", 32'(sum4), 32'(res[1] & 32'hF));
        check("cout4", 32'(cout4), 32'((res[1] >> 4) & 1));
        check("excl4", 32'(busy4 & done4), 32'd0);
      end
    end
  end

  // Start one op, then count edges after the accepting edge until done.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [7:0] es, input logic ec, input string nm);
    int n;
    @(posedge clk); #1;
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, "_lat"}, 32'(n), 32'd8);
    check({nm, "_sum"}, 32'(sum8), 32'(es));
    check({nm, "_cout"}, 32'(cout8), 32'(ec));
    @(posedge clk); #1;
    check({nm, "_fall"}, 32'(done8), 32'd0);
  endtask

  initial begin
    int n;
    int dones;
    #1;
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_done8", 32'(done8), 32'd0);
    check("rst_sum8", 32'(sum8), 32'd0);
    check("rst_cout8", 32'(cout8), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "zero");
    run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ff01");
    run8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, "a55a");

    // A second start three cycles into RUN must be ignored.
    @(posedge clk); #1;
    a8 = 8'h03; b8 = 8'h04; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 0;
    dones = 0;
    repeat (3) begin @(posedge clk); #1; n++; end
    a8 = 8'h10; b8 = 8'h10; start8 = 1'b1;
    @(posedge clk); #1; n++;
    start8 = 1'b0;
    while (!done8 && n < 40) begin @(posedge clk); #1; n++; end
    check("ign_lat", 32'(n), 32'd8);
    check("ign_sum", 32'(sum8), 32'h07);
    check("ign_cout", 32'(cout8), 32'd0);
    repeat (15) begin @(posedge clk); #1; if (done8) dones++; end
    check("ign_extra", 32'(dones), 32'd0);

    // Reset after four RUN edges aborts the op.
    @(posedge clk); #1;
    a8 = 8'h55; b8 = 8'h55; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_busy", 32'(busy8), 32'd0);
    check("mid_done", 32'(done8), 32'd0);
    check("mid_sum", 32'(sum8), 32'd0);
    check("mid_cout", 32'(cout8), 32'd0);
    dones = 0;
    repeat (3) begin @(posedge clk); #1; if (done8) dones++; end
    check("mid_nodone", 32'(dones), 32'd0);
    rst_n = 1'b1;
    run8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "after_rst");

    // start held high: back-to-back ops one per WIDTH+1 cycles.
    @(posedge clk); #1;
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!done8 && n < 40);
    check("hold1_lat", 32'(n), 32'd9);
    check("hold1_sum", 32'(sum8), 32'h02);
    check("hold1_cout", 32'(cout8), 32'd0);
    a8 = 8'h80; b8 = 8'h80;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!done8 && n < 40);
    start8 = 1'b0;
    check("hold2_gap", 32'(n), 32'd9);
    check("hold2_sum", 32'(sum8), 32'h00);
    check("hold2_cout", 32'(cout8), 32'd1);
    repeat (12) @(posedge clk);
    #1;

    // WIDTH=4 exhaustive sweep, start held high throughout.
    for (int i = 0; i < 512; i++) begin
      a4 = i[3:0]; b4 = i[7:4]; cin4 = i[8]; start4 = 1'b1;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!done4 && n < 40);
      check("ex4_lat", 32'(n), 32'd5);
      check("ex4_val", 32'({cout4, sum4}), 32'(i[3:0] + i[7:4] + i[8]));
      if (n >= 40) break;
    end
    start4 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got %0d want 0", 1);
    $fatal(1, "timeout");
  end

endmodule
